// File: rtl/tcb_pkg.sv
// tcb_pkg: types and helpers shared by TCB interconnect blocks.
//   rsp_ent_t    : response pipeline entry {valid, idx}, idx sized for up to PN_MAX ports
//   prio_search  : cyclic priority search starting at a pointer
// Used by tcb_arb (optional round-robin macro: TCB_ARB_ROUND_ROBIN_EN) and tcb_arb_rsp.
package tcb_pkg;

   localparam int unsigned IDX_W_MAX = 5;
   localparam int unsigned PN_MAX    = 32;

   typedef struct packed {
      logic                 valid;
      logic [IDX_W_MAX-1:0] idx;
   } rsp_ent_t;

   // First set bit of vld at or after ptr, wrapping pn-1 -> 0; returns 0 when none is set.
   function automatic logic [IDX_W_MAX-1:0] prio_search(
      input logic [PN_MAX-1:0]    vld,
      input logic [IDX_W_MAX-1:0] ptr,
      input int unsigned          pn
   );
      logic              found;
      int unsigned       idx;
      logic [PN_MAX-1:0] sh;
      prio_search = '0;
      found       = 1'b0;
      for (int unsigned k = 0; k < PN_MAX; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= pn) idx = idx - pn;
         sh = vld >> idx;
         if ((k < pn) && !found && sh[0]) begin
            found       = 1'b1;
            prio_search = IDX_W_MAX'(idx);
         end
      end
   endfunction

endpackage

// File: rtl/tcb_arb_rsp.sv
// tcb_arb_rsp: DLY-deep pipeline of {transfer, port index} that routes the
// manager error response back to the port that issued the transfer.
//   clk, rst (async, active-low)
//   xfer    : transfer accepted on the manager port this cycle
//   idx     : port index of that transfer
//   man_err : error from the shared resource (valid DLY cycles after a transfer)
//   sub_err : error routed to the issuing port only
module tcb_arb_rsp
   import tcb_pkg::*;
#(
   parameter int unsigned PN  = 2,
   parameter int unsigned IW  = $clog2(PN),
   parameter int unsigned DLY = 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          xfer,
   input  logic [IW-1:0] idx,
   input  logic          man_err,
   output logic [PN-1:0] sub_err
);

   rsp_ent_t ent_in;
   rsp_ent_t r;

   assign ent_in = '{valid: xfer, idx: IDX_W_MAX'(idx)};

   // Output stage: current transfer for DLY=0, otherwise the last pipeline stage.
   generate
      if (DLY == 0) begin : g_comb
         assign r = ent_in;
      end else begin : g_pipe
         rsp_ent_t [DLY-1:0] stg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               stg <= '0;
            end else begin
               stg[0] <= ent_in;
               for (int unsigned k = 1; k < DLY; k++) begin
                  stg[k] <= stg[k-1];
               end
            end
         end

         assign r = stg[DLY-1];
      end
   endgenerate

   // Error decode; indices >= PN never match.
   always_comb begin
      sub_err = '0;
      for (int unsigned i = 0; i < PN; i++) begin
         sub_err[i] = man_err & r.valid & (r.idx == IDX_W_MAX'(i));
      end
   end

endmodule

// File: rtl/tcb_arb.sv
// tcb_arb: shares one TCB manager port between PN requester ports.
// Request path is combinational; a stalled request locks the grant until it
// completes; responses are routed back in issue order after DLY cycles.
// Optional macro TCB_ARB_ROUND_ROBIN_EN: round-robin grant instead of fixed priority.
//   clk, rst (async, active-low)
//   sub_vld/wen/adr/ben/wdt : per-port requests
//   sub_rdt/err/rdy         : per-port responses
//   man_vld/wen/adr/ben/wdt : merged request to the shared resource
//   man_rdt/err/rdy         : response from the shared resource
module tcb_arb
   import tcb_pkg::*;
#(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned BW  = DW/8,
   parameter int unsigned PN  = 2,
   parameter int unsigned DLY = 1,
   parameter int unsigned IW  = $clog2(PN)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PN-1:0]          sub_vld,
   input  logic [PN-1:0]          sub_wen,
   input  logic [PN-1:0][AW-1:0]  sub_adr,
   input  logic [PN-1:0][BW-1:0]  sub_ben,
   input  logic [PN-1:0][DW-1:0]  sub_wdt,
   output logic [PN-1:0][DW-1:0]  sub_rdt,
   output logic [PN-1:0]          sub_err,
   output logic [PN-1:0]          sub_rdy,
   output logic                   man_vld,
   output logic                   man_wen,
   output logic [AW-1:0]          man_adr,
   output logic [BW-1:0]          man_ben,
   output logic [DW-1:0]          man_wdt,
   input  logic [DW-1:0]          man_rdt,
   input  logic                   man_err,
   input  logic                   man_rdy
);

   logic          lock;
   logic          lock_nxt;
   logic [IW-1:0] lock_idx;
   logic [IW-1:0] lock_idx_nxt;
   logic [IW-1:0] pick;
   logic [IW-1:0] g;
   logic          xfer;

`ifdef TCB_ARB_ROUND_ROBIN_EN
   logic [IW-1:0] ptr;

   assign pick = IW'(prio_search(PN_MAX'(sub_vld), IDX_W_MAX'(ptr), PN));

   // Pointer moves just past the port that completed a transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= (g == IW'(PN-1)) ? '0 : IW'(g + IW'(1));
      end
   end
`else
   assign pick = IW'(prio_search(PN_MAX'(sub_vld), '0, PN));
`endif

   // A held lock overrides arbitration so a stalled request is never replaced.
   assign g    = lock ? lock_idx : pick;
   assign xfer = man_vld & man_rdy;

   // Request mux
   assign man_vld = |sub_vld;
   assign man_wen = sub_wen[g];
   assign man_adr = sub_adr[g];
   assign man_ben = sub_ben[g];
   assign man_wdt = sub_wdt[g];

   always_comb begin
      sub_rdy    = '0;
      sub_rdy[g] = man_rdy;
   end

   // Read data is broadcast; only err needs routing.
   assign sub_rdt = {PN{man_rdt}};

   // Lock: set on a stall, cleared when the locked transfer completes or its vld drops.
   always_comb begin
      lock_nxt     = lock;
      lock_idx_nxt = lock_idx;
      if (lock) begin
         if (man_rdy || !sub_vld[lock_idx]) lock_nxt = 1'b0;
      end else if (man_vld && !man_rdy) begin
         lock_nxt     = 1'b1;
         lock_idx_nxt = g;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock     <= 1'b0;
         lock_idx <= '0;
      end else begin
         lock     <= lock_nxt;
         lock_idx <= lock_idx_nxt;
      end
   end

   tcb_arb_rsp #(
      .PN  (PN),
      .IW  (IW),
      .DLY (DLY)
   ) u_rsp (
      .clk     (clk),
      .rst     (rst),
      .xfer    (xfer),
      .idx     (g),
      .man_err (man_err),
      .sub_err (sub_err)
   );

endmodule

// File: tb/tb_tcb_arb.sv
// tb_tcb_arb: directed bench for tcb_arb.
// Instances: a (PN=2, DLY=1), b (PN=2, DLY=2), c (PN=3, DLY=0).
// Expectations follow TCB_ARB_ROUND_ROBIN_EN when that macro is defined.
module tb_tcb_arb;

`ifdef TCB_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic rst;
   logic [31:0] man_rdt;
   logic        man_err;
   logic        man_rdy;

   // instance a
   logic [1:0]        a_vld, a_wen, a_err, a_rdy;
   logic [1:0][31:0]  a_adr, a_wdt, a_rdt;
   logic [1:0][3:0]   a_ben;
   logic              a_mvld, a_mwen;
   logic [31:0]       a_madr, a_mwdt;
   logic [3:0]        a_mben;
   // instance b
   logic [1:0]        b_vld, b_wen, b_err, b_rdy;
   logic [1:0][31:0]  b_adr, b_wdt, b_rdt;
   logic [1:0][3:0]   b_ben;
   logic              b_mvld, b_mwen;
   logic [31:0]       b_madr, b_mwdt;
   logic [3:0]        b_mben;
   // instance c
   logic [2:0]        c_vld, c_wen, c_err, c_rdy;
   logic [2:0][31:0]  c_adr, c_wdt, c_rdt;
   logic [2:0][3:0]   c_ben;
   logic              c_mvld, c_mwen;
   logic [31:0]       c_madr, c_mwdt;
   logic [3:0]        c_mben;

   int checks = 0;
   int errors = 0;

   tcb_arb #(.AW(32), .DW(32), .BW(4), .PN(2), .DLY(1), .IW(1)) u_a (
      .clk(clk), .rst(rst),
      .sub_vld(a_vld), .sub_wen(a_wen), .sub_adr(a_adr), .sub_ben(a_ben), .sub_wdt(a_wdt),
      .sub_rdt(a_rdt), .sub_err(a_err), .sub_rdy(a_rdy),
      .man_vld(a_mvld), .man_wen(a_mwen), .man_adr(a_madr), .man_ben(a_mben), .man_wdt(a_mwdt),
      .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy)
   );

   tcb_arb #(.AW(32), .DW(32), .BW(4), .PN(2), .DLY(2), .IW(1)) u_b (
      .clk(clk), .rst(rst),
      .sub_vld(b_vld), .sub_wen(b_wen), .sub_adr(b_adr), .sub_ben(b_ben), .sub_wdt(b_wdt),
      .sub_rdt(b_rdt), .sub_err(b_err), .sub_rdy(b_rdy),
      .man_vld(b_mvld), .man_wen(b_mwen), .man_adr(b_madr), .man_ben(b_mben), .man_wdt(b_mwdt),
      .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy)
   );

   tcb_arb #(.AW(32), .DW(32), .BW(4), .PN(3), .DLY(0), .IW(2)) u_c (
      .clk(clk), .rst(rst),
      .sub_vld(c_vld), .sub_wen(c_wen), .sub_adr(c_adr), .sub_ben(c_ben), .sub_wdt(c_wdt),
      .sub_rdt(c_rdt), .sub_err(c_err), .sub_rdy(c_rdy),
      .man_vld(c_mvld), .man_wen(c_mwen), .man_adr(c_madr), .man_ben(c_mben), .man_wdt(c_mwdt),
      .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp2;
      logic [2:0] exp3;

      rst     = 1'b0;
      man_rdt = 32'h0;
      man_err = 1'b0;
      man_rdy = 1'b0;
      a_vld = '0; a_wen = '0; b_vld = '0; b_wen = '0; c_vld = '0; c_wen = '0;
      a_adr[0] = 32'h0000_1000; a_adr[1] = 32'h0000_0100;
      a_wdt[0] = 32'hAAAA_0000; a_wdt[1] = 32'h5555_0001;
      a_ben[0] = 4'hF;          a_ben[1] = 4'h3;
      b_adr[0] = 32'h0000_2000; b_adr[1] = 32'h0000_2004;
      b_wdt = '0; b_ben = '0;
      c_adr[0] = 32'h0000_3000; c_adr[1] = 32'h0000_3004; c_adr[2] = 32'h0000_3008;
      c_wdt = '0; c_ben = '0;

      // Reset state
      #3;
      chk("rst_a_err", 64'(a_err), 64'h0);
      chk("rst_b_err", 64'(b_err), 64'h0);
      chk("rst_c_err", 64'(c_err), 64'h0);
      chk("rst_a_mvld_idle", 64'(a_mvld), 64'h0);
      chk("rst_a_rdy", 64'(a_rdy), 64'h0);
      a_vld = 2'b10;
      #1;
      chk("rst_a_mvld_comb", 64'(a_mvld), 64'h1);
      chk("rst_a_madr_comb", 64'(a_madr), 64'h100);
      a_vld = 2'b00;
      step();
      step();
      rst = 1'b1;

      // Single read on port 1, error returned one cycle later
      step();
      a_vld = 2'b10; man_rdy = 1'b1; man_rdt = 32'hDEAD_BEEF;
      #2;
      chk("t1_madr", 64'(a_madr), 64'h100);
      chk("t1_mwen", 64'(a_mwen), 64'h0);
      chk("t1_rdy", 64'(a_rdy), 64'h2);
      chk("t1_err_early", 64'(a_err), 64'h0);
      chk("t1_rdt0", 64'(a_rdt[0]), 64'hDEAD_BEEF);
      chk("t1_rdt1", 64'(a_rdt[1]), 64'hDEAD_BEEF);
      step();
      a_vld = 2'b00; man_err = 1'b1;
      #2;
      chk("t1_err", 64'(a_err), 64'h2);
      step();
      #2;
      chk("t1_err_after", 64'(a_err), 64'h0);
      man_err = 1'b0;

      // Both ports valid for 6 cycles
      step();
      a_vld = 2'b11; a_wen = 2'b10; man_rdy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #2;
         exp2 = (RR && (k % 2 == 1)) ? 2'b10 : 2'b01;
         chk($sformatf("t2_rdy_%0d", k), 64'(a_rdy), 64'(exp2));
         chk($sformatf("t2_madr_%0d", k), 64'(a_madr),
             exp2[1] ? 64'h100 : 64'h1000);
         chk($sformatf("t2_mwdt_%0d", k), 64'(a_mwdt),
             exp2[1] ? 64'h5555_0001 : 64'hAAAA_0000);
         chk($sformatf("t2_mben_%0d", k), 64'(a_mben), exp2[1] ? 64'h3 : 64'hF);
         chk($sformatf("t2_mwen_%0d", k), 64'(a_mwen), exp2[1] ? 64'h1 : 64'h0);
         step();
      end
      a_vld = 2'b00; a_wen = 2'b00;

      // Stalled port 1 keeps the grant while port 0 waits
      for (int c = 1; c <= 5; c++) begin
         step();
         a_vld   = {1'(c <= 4), 1'(c >= 2)};
         man_rdy = (c >= 4);
         #2;
         chk($sformatf("t3_madr_c%0d", c), 64'(a_madr), (c <= 4) ? 64'h100 : 64'h1000);
         exp2 = (c <= 3) ? 2'b00 : ((c == 4) ? 2'b10 : 2'b01);
         chk($sformatf("t3_rdy_c%0d", c), 64'(a_rdy), 64'(exp2));
      end
      step();
      a_vld = 2'b00;

      // DLY=2 back-to-back transfers p0, p1, p0 with man_err held high
      man_rdy = 1'b1; man_err = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         b_vld = (c == 1 || c == 3) ? 2'b01 : ((c == 2) ? 2'b10 : 2'b00);
         #2;
         exp2 = (c == 3 || c == 5) ? 2'b01 : ((c == 4) ? 2'b10 : 2'b00);
         chk($sformatf("t4_err_c%0d", c), 64'(b_err), 64'(exp2));
         if (c == 2) chk("t4_madr_c2", 64'(b_madr), 64'h2004);
         step();
      end
      man_err = 1'b0;

      // PN=3, DLY=0: ports 0 and 2 valid after a transfer on port 0
      c_vld = 3'b001; man_rdy = 1'b1;
      #2;
      chk("t6_rdy_c1", 64'(c_rdy), 64'h1);
      step();
      c_vld = 3'b101; man_err = 1'b1;
      #2;
      exp3 = RR ? 3'b100 : 3'b001;
      chk("t6_rdy_c2", 64'(c_rdy), 64'(exp3));
      chk("t6_err_c2", 64'(c_err), 64'(exp3));
      chk("t6_madr_c2", 64'(c_madr), RR ? 64'h3008 : 64'h3000);
      step();
      man_err = 1'b0;
      #2;
      chk("t6_rdy_c3", 64'(c_rdy), 64'h1);
      step();
      c_vld = 3'b000;

      // Reset while port 1 is locked and a response is in flight
      b_vld = 2'b01; man_rdy = 1'b1;
      step();
      b_vld = 2'b10;
      step();
      man_rdy = 1'b0;
      step();
      b_vld = 2'b11; man_err = 1'b1;
      #2;
      chk("t5_lock_madr", 64'(b_madr), 64'h2004);
      chk("t5_lock_rdy", 64'(b_rdy), 64'h0);
      chk("t5_pending_err", 64'(b_err), 64'h2);
      #1;
      rst = 1'b0;
      #1;
      chk("t5_rst_err", 64'(b_err), 64'h0);
      step();
      rst = 1'b1; man_rdy = 1'b1;
      #2;
      chk("t5_post_rdy", 64'(b_rdy), 64'h1);
      chk("t5_post_madr", 64'(b_madr), 64'h2000);
      chk("t5_post_err0", 64'(b_err), 64'h0);
      step();
      b_vld = 2'b00;
      #2;
      chk("t5_post_err1", 64'(b_err), 64'h0);
      step();
      #2;
      chk("t5_post_err2", 64'(b_err), 64'h1);
      man_err = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
